// File: rtl/mean_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mean_pkg
//  Brief    : Shared types for the mean datapath and its sample packer.
//  Revision : 1.1 - add lane_cnt_width for packer lane-count sizing
// ============================================================================
package mean_pkg;

  localparam int data_width = 16;

  typedef logic [data_width-1:0] t_data;

  localparam int c_MAX_LANES = 16;

  typedef t_data t_data_array [0:c_MAX_LANES-1];

  // Bits needed to hold a lane count in the range 0..n
  function automatic int lane_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mean_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module   : mean_sample_packer
//  Brief    : Packs a serial t_data stream into BUS_WIDTH-lane vectors with a
//             valid/ready handoff, early close via s_last and a vector count.
//  Revision : 1.0 - initial release
// ============================================================================
module mean_sample_packer
  import mean_pkg::*;
#(
  parameter int BUS_WIDTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  t_data                                 s_data,
  input  logic                                  s_last,
  input  logic                                  o_ready,
  output logic                                  o_valid,
  output t_data                                 o_data [0:BUS_WIDTH-1],
  output logic [lane_cnt_width(BUS_WIDTH)-1:0]  o_count,
  output logic                                  o_last,
  output logic [CNT_WIDTH-1:0]                  o_vec_cnt
);

  localparam int c_PTR_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam int c_CNT_W = lane_cnt_width(BUS_WIDTH);
  localparam logic [c_PTR_W-1:0] c_LAST_LANE = c_PTR_W'(BUS_WIDTH - 1);

  logic [c_PTR_W-1:0] r_ptr;
  t_data              r_lane [0:BUS_WIDTH-1];
  t_data              w_out_lanes [0:BUS_WIDTH-1];
  logic               w_accept;
  logic               w_handoff;
  logic               w_complete;

  // Input stalls only while a finished vector is still waiting downstream
  assign s_ready    = rst & ~(o_valid & ~o_ready);
  assign w_accept   = s_valid & s_ready;
  assign w_handoff  = o_valid & o_ready;
  assign w_complete = w_accept & ((r_ptr == c_LAST_LANE) | s_last);

  // Lanes below ptr come from assembly, lane ptr is the arriving sample
  always_comb begin
    for (int i = 0; i < BUS_WIDTH; i++) begin
      if (c_PTR_W'(i) < r_ptr) begin
        w_out_lanes[i] = r_lane[i];
      end else if (c_PTR_W'(i) == r_ptr) begin
        w_out_lanes[i] = s_data;
      end else begin
        w_out_lanes[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_lane    <= '{default: '0};
      o_valid   <= 1'b0;
      o_data    <= '{default: '0};
      o_count   <= '0;
      o_last    <= 1'b0;
      o_vec_cnt <= '0;
    end else begin
      if (w_handoff) begin
        o_vec_cnt <= o_vec_cnt + CNT_WIDTH'(1);
      end
      if (w_complete) begin
        o_valid <= 1'b1;
        o_data  <= w_out_lanes;
        o_count <= c_CNT_W'(r_ptr) + c_CNT_W'(1);
        o_last  <= s_last;
        r_ptr   <= '0;
        r_lane  <= '{default: '0};
      end else begin
        if (w_handoff) begin
          o_valid <= 1'b0;
        end
        if (w_accept) begin
          r_lane[r_ptr] <= s_data;
          r_ptr         <= r_ptr + c_PTR_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
